binary_to_decimal_digits: RTL and testbench



---
 rtl/binary_to_decimal_digits_if.sv | 26 ++
 rtl/binary_to_decimal_digits.sv | 158 +++++++++++++++
 tb/tb_binary_to_decimal_digits.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/binary_to_decimal_digits_if.sv
// Handshake and result bundle for the binary-to-decimal digit converter.
// The master side requests conversions and the slave side (the converter)
// returns the busy/done status, the overflow flag and three decimal digits.
interface binary_to_decimal_digits_if #(
   parameter int INPUT_BITS = 10,
   parameter int DIGIT_BITS = 4
);
   logic                  start;
   logic [INPUT_BITS-1:0] value;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [DIGIT_BITS-1:0] number2;
   logic [DIGIT_BITS-1:0] number1;
   logic [DIGIT_BITS-1:0] number0;

   modport master (
      output start, value,
      input  busy, done, overflow, number2, number1, number0
   );

   modport slave (
      input  start, value,
      output busy, done, overflow, number2, number1, number0
   );
endinterface

// File: rtl/binary_to_decimal_digits.sv
// Iterative binary-to-BCD converter using shift-add-3, one input bit per clock.
// Produces hundreds/tens/units digits for the numeric on-screen readout. The
// digit outputs are only updated at the end of a conversion, so a partially
// converted number is never visible downstream.
// Optional build macro: SATURATE_EN -- when defined, an overflowing value
// (>= 1000) is shown as 9,9,9; otherwise the digits are value mod 1000.
module binary_to_decimal_digits #(
   parameter int INPUT_BITS = 10,
   parameter int DIGIT_BITS = 4
) (
   input logic                      clock,
   input logic                      reset_n,
   binary_to_decimal_digits_if.slave bus
);

   localparam int BCD_BITS     = 16;  // thousands, hundreds, tens, units
   localparam int SCRATCH_BITS = BCD_BITS + INPUT_BITS;
   localparam int COUNT_BITS   = $clog2(INPUT_BITS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [SCRATCH_BITS-1:0] scratch;
   logic [SCRATCH_BITS-1:0] scratch_next;
   logic [SCRATCH_BITS-1:0] adjusted;
   logic [COUNT_BITS-1:0]   count;
   logic [COUNT_BITS-1:0]   count_next;

   logic                    done_q;
   logic                    overflow_q;
   logic [DIGIT_BITS-1:0]   number2_q;
   logic [DIGIT_BITS-1:0]   number1_q;
   logic [DIGIT_BITS-1:0]   number0_q;

   logic [3:0]              bcd3;
   logic [3:0]              bcd2;
   logic [3:0]              bcd1;
   logic [3:0]              bcd0;
   logic                    result_overflow;
   logic [3:0]              result2;
   logic [3:0]              result1;
   logic [3:0]              result0;

   // Add 3 to every nibble that is 5 or more, so the following left shift
   // carries correctly into the next decimal digit.
   function automatic logic [BCD_BITS-1:0] add3(input logic [BCD_BITS-1:0] bcd);
      logic [BCD_BITS-1:0] r;
      r = bcd;
      for (int i = 0; i < BCD_BITS / 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign {bcd3, bcd2, bcd1, bcd0} = scratch[SCRATCH_BITS-1 -: BCD_BITS];
   assign adjusted = {add3(scratch[SCRATCH_BITS-1 -: BCD_BITS]), scratch[INPUT_BITS-1:0]};

   // State register.
   // NOTE: sequential blocks use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Next-state and scratch/counter update logic.
   // NOTE: every signal gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      next_state   = state;
      scratch_next = scratch;
      count_next   = count;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               scratch_next = {{BCD_BITS{1'b0}}, bus.value};
               count_next   = COUNT_BITS'(INPUT_BITS);
               next_state   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scratch_next = adjusted << 1;
            count_next   = count - COUNT_BITS'(1);
            if (count == COUNT_BITS'(1)) next_state = S_DONE;
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Scratch register and bit counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch <= '0;
         count   <= '0;
      end else begin
         scratch <= scratch_next;
         count   <= count_next;
      end
   end

   // Final digit selection; the thousands nibble only feeds the overflow flag.
   always_comb begin
      result_overflow = (bcd3 != 4'd0);
`ifdef SATURATE_EN
      if (result_overflow) begin
         result2 = 4'd9;
         result1 = 4'd9;
         result0 = 4'd9;
      end else begin
         result2 = bcd2;
         result1 = bcd1;
         result0 = bcd0;
      end
`else
      result2 = bcd2;
      result1 = bcd1;
      result0 = bcd0;
`endif
   end

   // Output registers: all digits and the overflow flag change together at
   // the DONE edge, with a one-cycle done pulse alongside.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         number2_q  <= '0;
         number1_q  <= '0;
         number0_q  <= '0;
      end else begin
         done_q <= (state == S_DONE);
         if (state == S_DONE) begin
            overflow_q <= result_overflow;
            number2_q  <= DIGIT_BITS'(result2);
            number1_q  <= DIGIT_BITS'(result1);
            number0_q  <= DIGIT_BITS'(result0);
         end
      end
   end

   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = done_q;
   assign bus.overflow = overflow_q;
   assign bus.number2  = number2_q;
   assign bus.number1  = number1_q;
   assign bus.number0  = number0_q;

endmodule

// File: tb/tb_binary_to_decimal_digits.sv
// Self-checking bench for binary_to_decimal_digits (INPUT_BITS=10).
// Table-driven conversions plus hand-written sequences for reset abort,
// ignored restarts and a continuous back-to-back sweep of every input value.
// Honours SATURATE_EN in its expected values.
module tb_binary_to_decimal_digits;

   localparam int INPUT_BITS = 10;
   localparam int DIGIT_BITS = 4;
   localparam int LATENCY    = INPUT_BITS + 1;
   localparam int PERIOD     = INPUT_BITS + 2;
   localparam int WAIT_LIMIT = 40;

   logic clk;
   logic reset_n;

   binary_to_decimal_digits_if #(.INPUT_BITS(INPUT_BITS), .DIGIT_BITS(DIGIT_BITS)) bus ();

   binary_to_decimal_digits #(.INPUT_BITS(INPUT_BITS), .DIGIT_BITS(DIGIT_BITS)) dut (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vectors;
   int n_miscompares;
   logic [31:0] last_exp;  // expected {overflow, number2, number1, number0}

   typedef struct {
      int         value;
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
      logic       ovf;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Expected packed result given the mod-1000 digits and overflow flag.
   function automatic logic [31:0] pack_exp(input logic ovf, input logic [3:0] d2,
                                            input logic [3:0] d1, input logic [3:0] d0);
`ifdef SATURATE_EN
      if (ovf) return {19'd0, 1'b1, 4'd9, 4'd9, 4'd9};
`endif
      return {19'd0, ovf, d2, d1, d0};
   endfunction

   // Independent reference: decimal arithmetic on the integer value.
   function automatic logic [31:0] model(input int v);
      int m;
      m = v % 1000;
      return pack_exp(v >= 1000, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10));
   endfunction

   function automatic logic [31:0] dut_pack();
      return {19'd0, bus.overflow, bus.number2, bus.number1, bus.number0};
   endfunction

   // One conversion from idle: checks busy, latency, digit hold, result and
   // the single-cycle done pulse.
   task automatic run_conv(input string name, input int v, input logic [31:0] expv);
      int  cycles;
      bit  hold_ok;
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = INPUT_BITS'(v);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.value = '0;
      check({name, " busy"}, 32'(bus.busy), 32'd1);
      cycles  = 0;
      hold_ok = 1'b1;
      while (cycles < WAIT_LIMIT) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (bus.done) break;
         if (dut_pack() !== last_exp) hold_ok = 1'b0;
      end
      check({name, " latency"}, 32'(cycles), 32'(LATENCY));
      check({name, " hold"}, 32'(hold_ok), 32'd1);
      check({name, " digits"}, dut_pack(), expv);
      check({name, " busy at done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check({name, " done pulse width"}, 32'(bus.done), 32'd0);
      last_exp = expv;
   endtask

   initial begin
      int dones;
      int cycles;
      logic [31:0] got;

      n_vectors     = 0;
      n_miscompares = 0;
      last_exp      = '0;
      bus.start     = 1'b0;
      bus.value     = '0;
      reset_n       = 1'b0;

      vecs[0]  = '{0,    4'd0, 4'd0, 4'd0, 1'b0};
      vecs[1]  = '{999,  4'd9, 4'd9, 4'd9, 1'b0};
      vecs[2]  = '{507,  4'd5, 4'd0, 4'd7, 1'b0};
      vecs[3]  = '{1023, 4'd0, 4'd2, 4'd3, 1'b1};
      vecs[4]  = '{100,  4'd1, 4'd0, 4'd0, 1'b0};
      vecs[5]  = '{99,   4'd0, 4'd9, 4'd9, 1'b0};
      vecs[6]  = '{1000, 4'd0, 4'd0, 4'd0, 1'b1};
      vecs[7]  = '{9,    4'd0, 4'd0, 4'd9, 1'b0};
      vecs[8]  = '{10,   4'd0, 4'd1, 4'd0, 1'b0};
      vecs[9]  = '{512,  4'd5, 4'd1, 4'd2, 1'b0};
      vecs[10] = '{256,  4'd2, 4'd5, 4'd6, 1'b0};
      vecs[11] = '{1,    4'd0, 4'd0, 4'd1, 1'b0};
      vecs[12] = '{990,  4'd9, 4'd9, 4'd0, 1'b0};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset digits", dut_pack(), 32'd0);
      reset_n = 1'b1;

      // Directed table, including 999 followed by 507 (hold) and 1023.
      for (int i = 0; i < 13; i++) begin
         run_conv($sformatf("vec%0d(%0d)", i, vecs[i].value), vecs[i].value,
                  pack_exp(vecs[i].ovf, vecs[i].d2, vecs[i].d1, vecs[i].d0));
      end

      // Reset in the middle of a conversion: immediate abort, no done later.
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = INPUT_BITS'(777);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort digits", dut_pack(), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      last_exp = '0;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("abort no done", 32'(dones), 32'd0);
      check("abort idle", 32'(bus.busy), 32'd0);

      // Zero after reset.
      run_conv("zero", 0, model(0));

      // Start pulses at cycles 3 and 7 of a conversion are ignored.
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = INPUT_BITS'(345);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      got   = '0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) begin
            dones++;
            got = dut_pack();
         end
         bus.start = (c == 3) || (c == 7);
         bus.value = (c == 3) ? INPUT_BITS'(678) : (c == 7) ? INPUT_BITS'(12) : INPUT_BITS'(0);
      end
      check("restart ignored done count", 32'(dones), 32'd1);
      check("restart ignored digits", got, model(345));
      last_exp = model(345);

      // Continuous start through every input value, back to back.
      @(negedge clk);
      bus.start = 1'b1;
      for (int v = 0; v < (1 << INPUT_BITS); v++) begin
         bus.value = INPUT_BITS'(v);
         cycles = 0;
         while (cycles < WAIT_LIMIT) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.done) break;
         end
         check($sformatf("sweep period %0d", v), 32'(cycles), 32'(PERIOD));
         check($sformatf("sweep value %0d", v), dut_pack(), model(v));
      end
      bus.start = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
